// File: rtl/alu_issue_stage.sv
// ID->EX issue register for the pipelined MIPS core.
// Decodes opcode/funct into a 4-bit ALU control code, selects both ALU
// operands and registers them with the EX-side controls behind a
// valid/ready handshake (stall hold, flush-to-bubble). Also keeps
// saturating counts of issued and illegal instructions.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    kill held/incoming op (branch redirect)
//   id_valid/id_ready        decode-side handshake (id_ready is combinational)
//   id_instr, id_rs_val/rt   instruction word and forwarded operands
//   ex_valid/ex_ready        EX-side handshake
//   ex_alucontrol, ex_first, ex_second, ex_dest, ex_regwrite,
//   ex_memread, ex_memwrite, ex_branch, ex_illegal   registered op toward EX
//   issue_cnt, illegal_cnt   saturating accept counters
module alu_issue_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [31:0]       id_instr,
  input  logic [DATA_W-1:0] id_rs_val,
  input  logic [DATA_W-1:0] id_rt_val,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [3:0]        ex_alucontrol,
  output logic [DATA_W-1:0] ex_first,
  output logic [DATA_W-1:0] ex_second,
  output logic [4:0]        ex_dest,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_branch,
  output logic              ex_illegal,
  output logic [CNT_W-1:0]  issue_cnt,
  output logic [CNT_W-1:0]  illegal_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_NOT = 6'b100111;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_NOT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1000;
  localparam logic [3:0] ALU_ILL = 4'b1111;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Instruction fields
  logic [5:0]  w_op;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt;
  logic [5:0]  w_funct;
  logic [15:0] w_imm;
  logic [DATA_W-1:0] w_sext_imm;
  logic [DATA_W-1:0] w_zext_imm;
  logic [DATA_W-1:0] w_shamt_ext;
  logic w_unused_rs;

  assign w_op        = id_instr[31:26];
  assign w_rt        = id_instr[20:16];
  assign w_rd        = id_instr[15:11];
  assign w_shamt     = id_instr[10:6];
  assign w_funct     = id_instr[5:0];
  assign w_imm       = id_instr[15:0];
  assign w_sext_imm  = {{(DATA_W-16){w_imm[15]}}, w_imm};
  assign w_zext_imm  = DATA_W'(w_imm);
  assign w_shamt_ext = DATA_W'(w_shamt);
  // The rs index is only needed upstream for forwarding.
  assign w_unused_rs = &{1'b0, id_instr[25:21]};

  // Decoded op
  logic [3:0]        w_alu;
  logic [DATA_W-1:0] w_first;
  logic [DATA_W-1:0] w_second;
  logic [4:0]        w_dest;
  logic              w_rw;
  logic              w_mr;
  logic              w_mw;
  logic              w_br;
  logic              w_ill;
  logic              w_accept;

  // Decode: default is the illegal encoding with R-type operand routing.
  always_comb begin
    w_alu    = ALU_ILL;
    w_first  = id_rs_val;
    w_second = id_rt_val;
    w_dest   = w_rd;
    w_rw     = 1'b0;
    w_mr     = 1'b0;
    w_mw     = 1'b0;
    w_br     = 1'b0;
    w_ill    = 1'b1;
    case (w_op)
      OP_RTYPE: begin
        w_ill = 1'b0;
        w_rw  = 1'b1;
        case (w_funct)
          FN_ADD: w_alu = ALU_ADD;
          FN_SUB: w_alu = ALU_SUB;
          FN_XOR: w_alu = ALU_XOR;
          FN_OR:  w_alu = ALU_OR;
          FN_AND: w_alu = ALU_AND;
          FN_NOT: w_alu = ALU_NOT;
          FN_SLT: w_alu = ALU_SLT;
          FN_SLL, FN_SRL: begin
            w_alu    = (w_funct == FN_SLL) ? ALU_SLL : ALU_SRL;
            w_first  = id_rt_val;
            w_second = w_shamt_ext;
          end
          default: begin
            w_ill = 1'b1;
            w_rw  = 1'b0;
          end
        endcase
      end
      OP_ADDI, OP_SLTI, OP_LW: begin
        w_alu    = (w_op == OP_SLTI) ? ALU_SLT : ALU_ADD;
        w_second = w_sext_imm;
        w_dest   = w_rt;
        w_rw     = 1'b1;
        w_mr     = (w_op == OP_LW);
        w_ill    = 1'b0;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        w_alu    = (w_op == OP_ANDI) ? ALU_AND :
                   (w_op == OP_ORI)  ? ALU_OR  : ALU_XOR;
        w_second = w_zext_imm;
        w_dest   = w_rt;
        w_rw     = 1'b1;
        w_ill    = 1'b0;
      end
      OP_SW: begin
        w_alu    = ALU_ADD;
        w_second = w_sext_imm;
        w_dest   = w_rt;
        w_mw     = 1'b1;
        w_ill    = 1'b0;
      end
      OP_BEQ: begin
        w_alu  = ALU_SUB;
        w_dest = w_rt;
        w_br   = 1'b1;
        w_ill  = 1'b0;
      end
      default: ;
    endcase
    // r0 is hardwired to zero, so never write it back.
    if (w_dest == 5'd0) w_rw = 1'b0;
  end

  // Issue register state
  logic              r_valid;
  logic [3:0]        r_alu;
  logic [DATA_W-1:0] r_first;
  logic [DATA_W-1:0] r_second;
  logic [4:0]        r_dest;
  logic              r_rw;
  logic              r_mr;
  logic              r_mw;
  logic              r_br;
  logic              r_ill;
  logic [CNT_W-1:0]  r_issue_cnt;
  logic [CNT_W-1:0]  r_illegal_cnt;

  assign id_ready = !r_valid || ex_ready;
  assign w_accept = id_valid && id_ready;

  // Payload only moves on a non-flushed accept, so stalls and bubbles hold it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid       <= 1'b0;
      r_alu         <= 4'd0;
      r_first       <= '0;
      r_second      <= '0;
      r_dest        <= 5'd0;
      r_rw          <= 1'b0;
      r_mr          <= 1'b0;
      r_mw          <= 1'b0;
      r_br          <= 1'b0;
      r_ill         <= 1'b0;
      r_issue_cnt   <= '0;
      r_illegal_cnt <= '0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid  <= 1'b1;
        r_alu    <= w_alu;
        r_first  <= w_first;
        r_second <= w_second;
        r_dest   <= w_dest;
        r_rw     <= w_rw;
        r_mr     <= w_mr;
        r_mw     <= w_mw;
        r_br     <= w_br;
        r_ill    <= w_ill;
      end else if (ex_ready) begin
        r_valid <= 1'b0;
      end

      if (w_accept && !flush) begin
        if (r_issue_cnt != CNT_MAX) r_issue_cnt <= r_issue_cnt + CNT_W'(1);
        if (w_ill && (r_illegal_cnt != CNT_MAX)) r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
      end
    end
  end

  assign ex_valid      = r_valid;
  assign ex_alucontrol = r_alu;
  assign ex_first      = r_first;
  assign ex_second     = r_second;
  assign ex_dest       = r_dest;
  assign ex_regwrite   = r_rw;
  assign ex_memread    = r_mr;
  assign ex_memwrite   = r_mw;
  assign ex_branch     = r_br;
  assign ex_illegal    = r_ill;
  assign issue_cnt     = r_issue_cnt;
  assign illegal_cnt   = r_illegal_cnt;

endmodule
